// File: rtl/next_pc_ctrl.sv
// next_pc_ctrl
//   Fetch-stage next-PC selection controller. Picks the source of the next
//   fetch address and tracks how many conditional branches are in flight.
//   When too many are unresolved it holds fetch. It also produces a start-up
//   hold for the first START_CYCLES clocks after reset, and on a mispredict
//   it restores the branch count to the number of older branches kept.
//
// Ports
//   clk               clock
//   rst_n             asynchronous active-low reset
//   stall_fetch       downstream fetch stall
//   stall_for_jump    stall while a jump target resolves
//   has_mispredict    branch mispredict this cycle
//   brch_keep         in-flight branches older than the mispredicted one
//   br_resolve        one in-flight branch resolved correctly this cycle
//   br_slot           per-slot conditional-branch flags (slot 0 = oldest)
//   pred_taken        per-slot taken predictions (ignored where br_slot=0)
//   jump_for_pcsel    unconditional jump in the fetch group
//   pcsel_from_bhndlr branch-handler overflow redirect
//   PC_select         next-PC mux select (combinational)
//   start             start-up hold active
//   brch_cnt          in-flight conditional branch count
//   brch_full         current group cannot be accepted (combinational)
module next_pc_ctrl #(
  parameter int FETCH_W      = 2,
  parameter int MAX_BRANCH   = 4,
  parameter int START_CYCLES = 1,
  parameter int CNT_W        = $clog2(MAX_BRANCH + 1),
  parameter int SEL_W        = $clog2(FETCH_W + 6)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_fetch,
  input  logic               stall_for_jump,
  input  logic               has_mispredict,
  input  logic [CNT_W-1:0]   brch_keep,
  input  logic               br_resolve,
  input  logic [FETCH_W-1:0] br_slot,
  input  logic [FETCH_W-1:0] pred_taken,
  input  logic               jump_for_pcsel,
  input  logic               pcsel_from_bhndlr,
  output logic [SEL_W-1:0]   PC_select,
  output logic               start,
  output logic [CNT_W-1:0]   brch_cnt,
  output logic               brch_full
);

  // Width of a per-group branch count and of the unwrapped full-check sum.
  localparam int NN_W    = $clog2(FETCH_W + 1);
  localparam int SUM_W   = CNT_W + NN_W;
  localparam int START_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  localparam logic [SEL_W-1:0] SEL_JUMP    = SEL_W'(FETCH_W);
  localparam logic [SEL_W-1:0] SEL_RECOVER = SEL_W'(FETCH_W + 1);
  localparam logic [SEL_W-1:0] SEL_BHNDLR  = SEL_W'(FETCH_W + 2);
  localparam logic [SEL_W-1:0] SEL_HOLD    = SEL_W'(FETCH_W + 3);
  localparam logic [SEL_W-1:0] SEL_SEQ     = SEL_W'(FETCH_W + 4);
  localparam logic [SEL_W-1:0] SEL_START   = SEL_W'(FETCH_W + 5);

  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_BRANCH);
  localparam logic [START_W-1:0] START_INIT = START_W'(START_CYCLES - 1);

  logic                start_r;
  logic [START_W-1:0]  start_cnt_r;
  logic [CNT_W-1:0]    brch_cnt_r;

  logic                taken_any_s;
  logic [SEL_W-1:0]    taken_idx_s;
  logic [NN_W-1:0]     n_new_s;
  logic [CNT_W-1:0]    cnt_after_res_s;
  logic [SUM_W-1:0]    sum_s;
  logic                brch_full_s;
  logic [SEL_W-1:0]    pc_sel_s;
  logic                advance_s;
  logic [CNT_W-1:0]    keep_clamped_s;
  logic [CNT_W-1:0]    cnt_next_s;

  // Find the oldest predicted-taken slot and count branches up to and
  // including it; younger slots are squashed by the taken redirect.
  always_comb begin
    taken_any_s = 1'b0;
    taken_idx_s = {SEL_W{1'b0}};
    n_new_s     = {NN_W{1'b0}};
    for (int i = 0; i < FETCH_W; i++) begin
      if (!taken_any_s) begin
        n_new_s = n_new_s + NN_W'(br_slot[i]);
        if (br_slot[i] && pred_taken[i]) begin
          taken_any_s = 1'b1;
          taken_idx_s = SEL_W'(i);
        end else begin
          taken_any_s = 1'b0;
        end
      end else begin
        taken_any_s = 1'b1;
      end
    end
  end

  // Net a resolve against the count (saturating at zero), then add the new
  // group's branches in a wide sum so the full test cannot wrap.
  always_comb begin
    if (br_resolve && (brch_cnt_r != {CNT_W{1'b0}})) begin
      cnt_after_res_s = brch_cnt_r - CNT_W'(1);
    end else begin
      cnt_after_res_s = brch_cnt_r;
    end
    sum_s       = SUM_W'(cnt_after_res_s) + SUM_W'(n_new_s);
    brch_full_s = (sum_s > SUM_W'(MAX_BRANCH));
  end

  // Next-PC source priority; start and recovery override any stall.
  always_comb begin
    if (start_r) begin
      pc_sel_s = SEL_START;
    end else if (has_mispredict) begin
      pc_sel_s = SEL_RECOVER;
    end else if (stall_fetch || stall_for_jump || brch_full_s) begin
      pc_sel_s = SEL_HOLD;
    end else if (jump_for_pcsel) begin
      pc_sel_s = SEL_JUMP;
    end else if (taken_any_s) begin
      pc_sel_s = taken_idx_s;
    end else if (pcsel_from_bhndlr) begin
      pc_sel_s = SEL_BHNDLR;
    end else begin
      pc_sel_s = SEL_SEQ;
    end
    advance_s = (pc_sel_s != SEL_START) && (pc_sel_s != SEL_RECOVER) &&
                (pc_sel_s != SEL_HOLD);
  end

  // Next branch count. An accepted group never exceeds MAX_BRANCH, so the
  // truncation of the wide sum on the advance path is lossless.
  always_comb begin
    if (brch_keep > CNT_MAX) begin
      keep_clamped_s = CNT_MAX;
    end else begin
      keep_clamped_s = brch_keep;
    end
    if (start_r) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (has_mispredict) begin
      cnt_next_s = keep_clamped_s;
    end else if (advance_s) begin
      cnt_next_s = CNT_W'(sum_s);
    end else begin
      cnt_next_s = cnt_after_res_s;
    end
  end

  // Start-up hold: stays high for START_CYCLES edges after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r     <= 1'b1;
      start_cnt_r <= START_INIT;
    end else if (start_r) begin
      if (start_cnt_r == {START_W{1'b0}}) begin
        start_r <= 1'b0;
      end else begin
        start_cnt_r <= start_cnt_r - START_W'(1);
      end
    end
  end

  // In-flight branch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brch_cnt_r <= {CNT_W{1'b0}};
    end else begin
      brch_cnt_r <= cnt_next_s;
    end
  end

  assign PC_select = pc_sel_s;
  assign start     = start_r;
  assign brch_cnt  = brch_cnt_r;
  assign brch_full = brch_full_s;

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Testbench for next_pc_ctrl with FETCH_W=4, MAX_BRANCH=4, START_CYCLES=3.
// Table-driven vectors plus hand-written start-up and async-reset sequences.
module tb_next_pc_ctrl;

  localparam int FW    = 4;
  localparam int MAXB  = 4;
  localparam int STC   = 3;
  localparam int CNT_W = 3;
  localparam int SEL_W = 4;

  localparam logic [3:0] S_JUMP  = 4'd4;
  localparam logic [3:0] S_REC   = 4'd5;
  localparam logic [3:0] S_BH    = 4'd6;
  localparam logic [3:0] S_HOLD  = 4'd7;
  localparam logic [3:0] S_SEQ   = 4'd8;
  localparam logic [3:0] S_START = 4'd9;

  logic             clk;
  logic             rst_n;
  logic             stall_fetch;
  logic             stall_for_jump;
  logic             has_mispredict;
  logic [CNT_W-1:0] brch_keep;
  logic             br_resolve;
  logic [FW-1:0]    br_slot;
  logic [FW-1:0]    pred_taken;
  logic             jump_for_pcsel;
  logic             pcsel_from_bhndlr;
  logic [SEL_W-1:0] PC_select;
  logic             start;
  logic [CNT_W-1:0] brch_cnt;
  logic             brch_full;

  int checks = 0;
  int errors = 0;

  next_pc_ctrl #(
    .FETCH_W(FW), .MAX_BRANCH(MAXB), .START_CYCLES(STC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_fetch(stall_fetch), .stall_for_jump(stall_for_jump),
    .has_mispredict(has_mispredict), .brch_keep(brch_keep),
    .br_resolve(br_resolve), .br_slot(br_slot), .pred_taken(pred_taken),
    .jump_for_pcsel(jump_for_pcsel), .pcsel_from_bhndlr(pcsel_from_bhndlr),
    .PC_select(PC_select), .start(start), .brch_cnt(brch_cnt),
    .brch_full(brch_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             sf;
    logic             sj;
    logic             mp;
    logic [CNT_W-1:0] keep;
    logic             res;
    logic [FW-1:0]    slot;
    logic [FW-1:0]    pred;
    logic             jmp;
    logic             bh;
    logic [SEL_W-1:0] esel;
    logic             efull;
    logic [CNT_W-1:0] ecnt;   // count seen before this row's clock edge
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic sf, logic sj, logic mp, logic [2:0] keep,
                              logic res, logic [3:0] slot, logic [3:0] pred,
                              logic jmp, logic bh, logic [3:0] esel,
                              logic efull, logic [2:0] ecnt);
    vec_t v;
    v.sf = sf; v.sj = sj; v.mp = mp; v.keep = keep; v.res = res;
    v.slot = slot; v.pred = pred; v.jmp = jmp; v.bh = bh;
    v.esel = esel; v.efull = efull; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    stall_fetch = 1'b0; stall_for_jump = 1'b0; has_mispredict = 1'b0;
    brch_keep = 3'd0; br_resolve = 1'b0; br_slot = 4'd0; pred_taken = 4'd0;
    jump_for_pcsel = 1'b0; pcsel_from_bhndlr = 1'b0;
  endtask

  initial begin
    //         sf   sj   mp   keep  res  slot     pred     jmp  bh   sel      full cnt
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b0000,4'b0000,1'b0,1'b0,S_SEQ, 1'b0,3'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b1110,4'b1100,1'b0,1'b0,4'd2,  1'b0,3'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b0001,4'b0000,1'b0,1'b0,S_SEQ, 1'b0,3'd2));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b0011,4'b0000,1'b0,1'b0,S_HOLD,1'b1,3'd3));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b1,4'b0011,4'b0000,1'b0,1'b0,S_SEQ, 1'b0,3'd3));
    vq.push_back(mk(1'b1,1'b0,1'b1,3'd1,1'b0,4'b0011,4'b0000,1'b1,1'b0,S_REC, 1'b1,3'd4));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b0000,4'b0000,1'b1,1'b1,S_JUMP,1'b0,3'd1));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b0000,4'b0000,1'b0,1'b1,S_BH,  1'b0,3'd1));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b0100,4'b0100,1'b0,1'b1,4'd2,  1'b0,3'd1));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b1,4'b0000,4'b0000,1'b0,1'b0,S_SEQ, 1'b0,3'd2));
    vq.push_back(mk(1'b0,1'b1,1'b0,3'd0,1'b1,4'b0000,4'b0000,1'b0,1'b0,S_HOLD,1'b0,3'd1));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b1,4'b0000,4'b0000,1'b0,1'b0,S_SEQ, 1'b0,3'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b1,4'b0000,4'b0000,1'b0,1'b0,S_SEQ, 1'b0,3'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b1111,4'b0000,1'b0,1'b0,S_SEQ, 1'b0,3'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b0001,4'b0000,1'b0,1'b0,S_HOLD,1'b1,3'd4));
    vq.push_back(mk(1'b0,1'b0,1'b1,3'd7,1'b0,4'b0000,4'b0000,1'b0,1'b0,S_REC, 1'b0,3'd4));
    vq.push_back(mk(1'b0,1'b0,1'b1,3'd0,1'b0,4'b0000,4'b0000,1'b0,1'b0,S_REC, 1'b0,3'd4));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b1010,4'b1010,1'b0,1'b0,4'd1,  1'b0,3'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b0001,4'b0001,1'b1,1'b0,S_JUMP,1'b0,3'd1));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b0000,4'b1111,1'b0,1'b0,S_SEQ, 1'b0,3'd2));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b0001,4'b0000,1'b0,1'b0,S_SEQ, 1'b0,3'd2));
    vq.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,4'b0000,4'b0000,1'b0,1'b0,S_SEQ, 1'b0,3'd3));

    // Reset state.
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_start", 32'(start), 32'd1);
    check("reset_sel", 32'(PC_select), 32'(S_START));
    check("reset_cnt", 32'(brch_cnt), 32'd0);

    // Start-up hold lasts exactly three edges; a mispredict inside it is ignored.
    rst_n = 1'b1;
    @(negedge clk);
    check("start_c0", 32'(start), 32'd1);
    @(posedge clk); #1;
    has_mispredict = 1'b1; brch_keep = 3'd3;
    @(negedge clk);
    check("start_c1", 32'(start), 32'd1);
    check("start_c1_sel", 32'(PC_select), 32'(S_START));
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("start_c2", 32'(start), 32'd1);
    check("start_mp_ignored", 32'(brch_cnt), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("start_done", 32'(start), 32'd0);
    check("start_done_sel", 32'(PC_select), 32'(S_SEQ));
    check("start_done_cnt", 32'(brch_cnt), 32'd0);

    // Table-driven vectors, one per cycle.
    for (int i = 0; i < vq.size(); i++) begin
      stall_fetch = vq[i].sf; stall_for_jump = vq[i].sj;
      has_mispredict = vq[i].mp; brch_keep = vq[i].keep;
      br_resolve = vq[i].res; br_slot = vq[i].slot; pred_taken = vq[i].pred;
      jump_for_pcsel = vq[i].jmp; pcsel_from_bhndlr = vq[i].bh;
      @(negedge clk);
      check($sformatf("v%0d_cnt", i), 32'(brch_cnt), 32'(vq[i].ecnt));
      check($sformatf("v%0d_sel", i), 32'(PC_select), 32'(vq[i].esel));
      check($sformatf("v%0d_full", i), 32'(brch_full), 32'(vq[i].efull));
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a cycle with three branches in flight.
    drive_idle();
    @(negedge clk);
    check("pre_rst_cnt", 32'(brch_cnt), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(brch_cnt), 32'd0);
    check("async_rst_start", 32'(start), 32'd1);
    check("async_rst_sel", 32'(PC_select), 32'(S_START));
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
